// File: rtl/count_seg_display.sv
// Two-digit decimal display of a 4-bit count, scanned over a 4-digit seven-segment display.
// Optional macro DIR_DP_EN lights DIG0's decimal point while the displayed value is descending.
module count_seg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_e;

  slot_e         slot, slot_nxt;
  logic [CW-1:0] rcnt;
  logic          slot_adv, frame_latch;
  logic [3:0]    count_q, disp_val, tens, ones, digit;
  logic          dig_on, dir_down;
  logic [3:0]    an_h;
  logic [6:0]    seg_h;
  logic          dp_h;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign slot_adv    = (rcnt == CNT_MAX);
  assign frame_latch = slot_adv && (slot == DIG3);

  assign tens = (disp_val >= 4'd10) ? 4'd1 : 4'd0;
  assign ones = disp_val - ((disp_val >= 4'd10) ? 4'd10 : 4'd0);

  // disp_val only moves at frame start so both digits of a frame agree
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      slot     <= DIG0;
      count_q  <= 4'd0;
      disp_val <= 4'd0;
    end else begin
      count_q <= count;
      rcnt    <= slot_adv ? '0 : rcnt + 1'b1;
      slot    <= slot_nxt;
      if (frame_latch) disp_val <= count_q;
    end
  end

`ifdef DIR_DP_EN
  logic [3:0] prev_val;
  logic       latch_d;

  // direction settles on the blank first cycle of DIG0, before any dp is shown
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_val <= 4'd0;
      latch_d  <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      latch_d <= frame_latch;
      if (frame_latch) prev_val <= disp_val;
      if (latch_d) begin
        if (disp_val < prev_val)      dir_down <= 1'b1;
        else if (disp_val > prev_val) dir_down <= 1'b0;
      end
    end
  end
`else
  assign dir_down = 1'b0;
`endif

  always_comb begin
    slot_nxt = slot;
    if (slot_adv) begin
      case (slot)
        DIG0:    slot_nxt = DIG1;
        DIG1:    slot_nxt = DIG2;
        DIG2:    slot_nxt = DIG3;
        default: slot_nxt = DIG0;
      endcase
    end
  end

  always_comb begin
    dig_on = 1'b0;
    digit  = ones;
    case (slot)
      DIG0: begin
        dig_on = 1'b1;
        digit  = ones;
      end
      DIG1: begin
        dig_on = (tens != 4'd0);
        digit  = tens;
      end
      default: dig_on = 1'b0;
    endcase
    // blank first cycle of every slot to stop ghosting between digits
    if (rcnt == '0) dig_on = 1'b0;
    an_h  = dig_on ? (4'b0001 << slot) : 4'b0000;
    seg_h = dig_on ? seg7(digit) : 7'h00;
    dp_h  = dig_on && (slot == DIG0) && dir_down;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {4{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= an_h ^ {4{ACTIVE_LOW}};
      seg <= seg_h ^ {7{ACTIVE_LOW}};
      dp  <= dp_h ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_count_seg_display.sv
// Scoreboard bench for count_seg_display: a frame-position model predicts every registered output.
module tb_count_seg_display;
  localparam int R  = 4;
  localparam int FR = 4 * R;
  localparam logic [6:0] FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  count_seg_display #(.REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .count(count),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pos = 0, m_cq = 0, m_disp = 0;
  bit   m_down = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one clock: predict output of this edge, advance model, compare after edge
  task automatic step();
    out_t e;
    int   dig, sub, tn, on;
    bit   act;
    if (rst) e = {4'hF, 7'h7F, 1'b1};
    else begin
      dig   = m_pos / R;
      sub   = m_pos % R;
      tn    = m_disp / 10;
      on    = m_disp % 10;
      act   = (sub != 0) && (dig == 0 || (dig == 1 && tn != 0));
      e.an  = act ? ~(4'(1 << dig)) : 4'hF;
      e.seg = act ? ~FONT[(dig == 0) ? on : tn] : 7'h7F;
`ifdef DIR_DP_EN
      e.dp  = !(act && dig == 0 && m_down);
`else
      e.dp  = 1'b1;
`endif
    end
    exp_q.push_back(e);
    if (rst) begin
      m_pos = 0; m_cq = 0; m_disp = 0; m_down = 1'b0;
    end else begin
      if (m_pos == FR - 1) begin
        if (m_cq < m_disp)      m_down = 1'b1;
        else if (m_cq > m_disp) m_down = 1'b0;
        m_disp = m_cq;
      end
      m_pos = (m_pos + 1) % FR;
      m_cq  = int'(count);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("an", 32'(an), 32'(e.an));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dp", 32'(dp), 32'(e.dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FR && m_pos != p; i++) step();
  endtask

  initial begin
    int         lat;
    logic [6:0] want;

    rst = 1'b1;
    run(3);
    chk("rst_an", 32'(an), 32'h0F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    rst = 1'b0;

    count = 4'd5;
    run(3 * FR);
    count = 4'd13;
    run(3 * FR);

    // worst case: change arrives just as the frame latch takes the old value
    wait_pos(FR - 1);
    count = 4'd7;
    want  = ~FONT[7];
    lat   = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (an == 4'hE && seg == want) break;
      lat++;
    end
    chk("lat_worst_le18", 32'(lat <= 4 * R + 2), 32'h1);

    count = 4'd9;
    run(2 * FR);
    wait_pos(R + 1);
    count = 4'd10;
    want  = ~FONT[0];
    lat   = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (an == 4'hE && seg == want) break;
      lat++;
    end
    chk("lat_mid_le18", 32'(lat <= 4 * R + 2), 32'h1);
    run(2 * FR);

    // reset pulse inside DIG2
    count = 4'd11;
    wait_pos(2 * R + 1);
    rst = 1'b1;
    step();
    chk("rst_mid_an", 32'(an), 32'h0F);
    rst = 1'b0;
    run(3 * FR);

    count = 4'd15;
    run(2 * FR);
    count = 4'd14;
    run(2 * FR);
    count = 4'd15;
    run(2 * FR);
    count = 4'd15;
    run(FR);

    for (int k = 0; k < 20; k++) begin
      count = 4'($urandom_range(0, 15));
      run($urandom_range(1, 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
Downstream consumer of the 4-bit up/down counter value. Converts the count (0-15) to two decimal digits and time-multiplexes them onto a 4-digit seven-segment display, scanning one digit per refresh slot. Latches a new count only at frame start, so digits never tear mid-scan. Board clock domain (100 MHz).

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^20
ACTIVE_LOW, 1, 1 = segments/anodes/dp active-low (common-anode board); 0 = active-high

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
count  input  4  counter value, 0..15, treated as asynchronous-to-slot data in the clk domain
an  output  4  digit anode enables, an[0] = rightmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, seg[0] = a
dp  output  1  decimal point of the currently enabled digit

Behaviour:
- Clock/reset: one clock (clk); rst synchronous, active-high, sampled on posedge clk. All state is updated on posedge clk only.
- Reset values: refresh counter = 0; slot = DIG0; count_q = 0; disp_val = 0; an = all inactive; seg = all off; dp = off (inactive level per ACTIVE_LOW).
- Input stage: count registered into count_q every cycle (1-cycle capture).
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps to 0. A slot_adv strobe is asserted on the wrap cycle.
- Slot FSM: DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0, advancing on slot_adv only. rst mid-frame returns the FSM to DIG0 with the counter at 0 on the next edge.
- Frame latch: on the slot_adv that enters DIG0, disp_val <= count_q. disp_val is constant for the whole frame.
- Conversion: tens = (disp_val >= 10); ones = disp_val - (tens ? 10 : 0). Both are 4-bit, unsigned, combinational from disp_val.
- Digit content:
  - DIG0 = ones.
  - DIG1 = tens.
  - DIG1 is blanked (anode inactive) when tens = 0.
  - DIG2 and DIG3 are always blanked (anodes inactive).
- Anti-ghosting: on the first cycle of every slot (refresh counter = 0), all anodes are inactive. The slot's anode is active from counter = 1 to REFRESH_DIV-1.
- Registered outputs: an, seg and dp are registered. They reflect slot/counter state with 1-cycle latency.
- Segment encoding, active-high form before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Any value above 9 (unreachable) encodes as 00.
  - When ACTIVE_LOW=1, seg, an and dp are bitwise-inverted.
- Latency: a count change reaches the display no later than 4*REFRESH_DIV + 2 cycles after it appears on count.
- Simultaneous events: rst overrides slot_adv and the frame latch in the same cycle.

Optional Feature:
Macro DIR_DP_EN.
- Defined:
  - Adds register prev_val, loaded with the old disp_val at each frame latch.
  - dp is active during active DIG0 cycles when the new disp_val < prev_val, i.e. the counter is descending.
  - Equal values keep the previous dp decision.
  - Reset clears prev_val to 0 and the direction flag to "up".
- Not defined: no prev_val register; dp is permanently inactive.

Test Plan:
1. REFRESH_DIV=4, ACTIVE_LOW=1, assert rst 3 cycles -> an=4'hF, seg=7'h7F, dp=1. Slot=DIG0 one cycle after release.
2. count=5 held -> each frame: DIG0 active (an=4'hE) for 3 of 4 cycles with seg=7'h12; an=4'hF in DIG1/DIG2/DIG3 and on every slot's first cycle.
3. count=13 -> DIG0 seg=7'h30 ("3") with an=4'hE; DIG1 seg=7'h79 ("1") with an=4'hD.
4. Change count 9->10 in mid-DIG1 -> the remainder of the frame still shows 9; the next DIG0 shows "0" with tens "1". Verify the worst case stays within 4*4+2 = 18 cycles.
5. Assert rst during DIG2 for 1 cycle -> the next edge gives counter 0, slot DIG0, an=4'hF, disp_val=0. Then normal scanning resumes showing the current count.
6. With DIR_DP_EN, frames showing 15 then 14 -> dp=0 during active DIG0 of the 14 frame. Frames 14 then 15 -> dp=1. Without the macro, dp=1 throughout.
